// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - format codes and opcode constants for the immediate generation stage
package imm_gen_pkg;

    // Format codes carried on out_fmt
    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational instruction format classifier and immediate extender
//
// Ports:
//   instr    in   32          instruction word
//   sextimm  out  DATA_WIDTH  immediate, sign-extended (shift amounts zero-extended)
//   fmt      out  FMT_WIDTH   format code (FMT_NONE..FMT_SHAMT)
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FMT_WIDTH  = 3
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] sextimm,
    output logic [FMT_WIDTH-1:0]  fmt
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    logic        shamt_msb;
    logic [31:0] imm32;
    logic [2:0]  fmt_c;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // shamt[5] only exists on RV64; on RV32 instr[25] belongs to funct7
    assign shamt_msb = (DATA_WIDTH == 64) ? instr[25] : 1'b0;

    always_comb begin
        imm32 = 32'd0;
        fmt_c = FMT_NONE;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                fmt_c = FMT_I;
            end
            OP_IMM: begin
                if (is_shift) begin
                    imm32 = {26'd0, shamt_msb, instr[24:20]};
                    fmt_c = FMT_SHAMT;
                end else begin
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                    fmt_c = FMT_I;
                end
            end
            OP_IMM32: begin
                // Word-sized immediate ops only exist on RV64
                if (DATA_WIDTH == 64) begin
                    if (is_shift) begin
                        imm32 = {26'd0, shamt_msb, instr[24:20]};
                        fmt_c = FMT_SHAMT;
                    end else begin
                        imm32 = {{20{instr[31]}}, instr[31:20]};
                        fmt_c = FMT_I;
                    end
                end
            end
            OP_STORE: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt_c = FMT_S;
            end
            OP_BRANCH: begin
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt_c = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {instr[31:12], 12'd0};
                fmt_c = FMT_U;
            end
            OP_JAL: begin
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt_c = FMT_J;
            end
            default: begin
                imm32 = 32'd0;
                fmt_c = FMT_NONE;
            end
        endcase
    end

    // imm32 already carries its sign in bit 31; widen to DATA_WIDTH by sign extension
    assign sextimm = DATA_WIDTH'($signed(imm32));
    assign fmt     = FMT_WIDTH'(fmt_c);

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered valid/ready immediate generation stage with skid buffer and flush
//
// Optional macro IMM_GEN_TARGET_EN adds out_target = out_pc + out_sextimm for B, J and AUIPC.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   flush            drop every buffered entry (wins over a same-cycle accept)
//   in_valid/ready   upstream handshake; in_ready is registered (skid empty)
//   in_instr, in_pc  instruction word and its PC
//   out_valid/ready  downstream handshake
//   out_instr/pc     passthrough of the accepted instruction and PC
//   out_sextimm      extended immediate
//   out_fmt          format code
//   out_target       branch/jump/auipc target (only with IMM_GEN_TARGET_EN)
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FMT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_sextimm,
`ifdef IMM_GEN_TARGET_EN
    output logic [DATA_WIDTH-1:0] out_target,
`endif
    output logic [FMT_WIDTH-1:0]  out_fmt
);

    logic [DATA_WIDTH-1:0] dec_sextimm;
    logic [FMT_WIDTH-1:0]  dec_fmt;

    imm_decode #(
        .DATA_WIDTH(DATA_WIDTH),
        .FMT_WIDTH (FMT_WIDTH)
    ) u_decode (
        .instr  (in_instr),
        .sextimm(dec_sextimm),
        .fmt    (dec_fmt)
    );

    // Skid entry
    logic                  skid_valid;
    logic [31:0]           skid_instr;
    logic [DATA_WIDTH-1:0] skid_pc;
    logic [DATA_WIDTH-1:0] skid_sextimm;
    logic [FMT_WIDTH-1:0]  skid_fmt;

`ifdef IMM_GEN_TARGET_EN
    logic                  dec_has_target;
    logic [DATA_WIDTH-1:0] dec_target;
    logic [DATA_WIDTH-1:0] skid_target;

    // LUI shares FMT_U with AUIPC, so the opcode separates them
    assign dec_has_target = (dec_fmt == FMT_WIDTH'(FMT_B)) ||
                            (dec_fmt == FMT_WIDTH'(FMT_J)) ||
                            (in_instr[6:0] == OP_AUIPC);
    assign dec_target     = dec_has_target ? (in_pc + dec_sextimm) : '0;
`endif

    logic accept;
    logic out_free;

    assign accept   = in_valid && in_ready;
    // Output register can take a new entry this cycle: empty or being drained
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_sextimm  <= '0;
            out_fmt      <= '0;
            skid_valid   <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
            skid_sextimm <= '0;
            skid_fmt     <= '0;
`ifdef IMM_GEN_TARGET_EN
            out_target   <= '0;
            skid_target  <= '0;
`endif
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (out_free) begin
            if (skid_valid) begin
                // in_ready is low while the skid is full, so no accept can coincide here
                out_valid   <= 1'b1;
                out_instr   <= skid_instr;
                out_pc      <= skid_pc;
                out_sextimm <= skid_sextimm;
                out_fmt     <= skid_fmt;
`ifdef IMM_GEN_TARGET_EN
                out_target  <= skid_target;
`endif
                skid_valid  <= 1'b0;
                in_ready    <= 1'b1;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_instr   <= in_instr;
                    out_pc      <= in_pc;
                    out_sextimm <= dec_sextimm;
                    out_fmt     <= dec_fmt;
`ifdef IMM_GEN_TARGET_EN
                    out_target  <= dec_target;
`endif
                end
            end
        end else if (accept) begin
            // Output is stalled: park the new entry and close the input
            skid_valid   <= 1'b1;
            skid_instr   <= in_instr;
            skid_pc      <= in_pc;
            skid_sextimm <= dec_sextimm;
            skid_fmt     <= dec_fmt;
`ifdef IMM_GEN_TARGET_EN
            skid_target  <= dec_target;
`endif
            in_ready     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed self-checking bench for imm_gen_stage (RV32 and RV64 instances)
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_sextimm;
    logic [2:0]  out_fmt;

    logic        in_ready64;
    logic        out_valid64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64;
    logic [63:0] out_sextimm64;
    logic [2:0]  out_fmt64;
    logic [63:0] in_pc64;

`ifdef IMM_GEN_TARGET_EN
    logic [31:0] out_target;
    logic [63:0] out_target64;
`endif

    int checks = 0;
    int errors = 0;

    assign in_pc64 = {32'd0, in_pc};

    always #5 clk = ~clk;

    imm_gen_stage #(.DATA_WIDTH(32), .FMT_WIDTH(3)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_sextimm(out_sextimm),
`ifdef IMM_GEN_TARGET_EN
        .out_target (out_target),
`endif
        .out_fmt    (out_fmt)
    );

    imm_gen_stage #(.DATA_WIDTH(64), .FMT_WIDTH(3)) u_dut64 (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready64),
        .in_instr   (in_instr),
        .in_pc      (in_pc64),
        .out_valid  (out_valid64),
        .out_ready  (out_ready),
        .out_instr  (out_instr64),
        .out_pc     (out_pc64),
        .out_sextimm(out_sextimm64),
`ifdef IMM_GEN_TARGET_EN
        .out_target (out_target64),
`endif
        .out_fmt    (out_fmt64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction through an unstalled stage; results checked one cycle after accept
    task automatic single(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [2:0] fmt, input logic [31:0] imm,
                          input logic [2:0] fmt64, input logic [63:0] imm64,
                          input logic [31:0] tgt);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".instr"}, 64'(out_instr), 64'(instr));
        check({tag, ".pc"}, 64'(out_pc), 64'(pc));
        check({tag, ".fmt"}, 64'(out_fmt), 64'(fmt));
        check({tag, ".imm"}, 64'(out_sextimm), 64'(imm));
        check({tag, ".valid64"}, 64'(out_valid64), 64'd1);
        check({tag, ".fmt64"}, 64'(out_fmt64), 64'(fmt64));
        check({tag, ".imm64"}, out_sextimm64, imm64);
`ifdef IMM_GEN_TARGET_EN
        check({tag, ".target"}, 64'(out_target), 64'(tgt));
`else
        if (tgt != tgt) check({tag, ".unused"}, 64'd0, 64'd1);
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    localparam logic [31:0] I_ADDI  = 32'hFFF00093;
    localparam logic [31:0] I_SW    = 32'hFE112E23;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_JAL   = 32'hFF9FF06F;

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);

        // Reset state
        @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.imm", 64'(out_sextimm), 64'd0);
        check("rst.fmt", 64'(out_fmt), 64'd0);
        check("rst.instr", 64'(out_instr), 64'd0);
        check("rst.pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Decode table: tag, instr, pc, fmt32, imm32, fmt64, imm64, target32
        single("addi",  I_ADDI,        32'h0000_0000, 3'd1, 32'hFFFF_FFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0);
        single("sw",    I_SW,          32'h0000_0004, 3'd2, 32'hFFFF_FFFC, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0);
        single("lui",   I_LUI,         32'h0000_0008, 3'd4, 32'h1234_5000, 3'd4, 64'h0000_0000_1234_5000, 32'h0);
        single("luineg",32'h800000B7,  32'h0000_000C, 3'd4, 32'h8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0000, 32'h0);
        single("jal",   I_JAL,         32'h0000_0100, 3'd5, 32'hFFFF_FFF8, 3'd5, 64'hFFFF_FFFF_FFFF_FFF8, 32'h0000_00F8);
        single("jalwrap",I_JAL,        32'h0000_0004, 3'd5, 32'hFFFF_FFF8, 3'd5, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFFC);
        single("srai",  32'h4030D093,  32'h0000_0010, 3'd6, 32'h0000_0003, 3'd6, 64'h0000_0000_0000_0003, 32'h0);
        single("slli33",32'h02109093,  32'h0000_0014, 3'd6, 32'h0000_0001, 3'd6, 64'h0000_0000_0000_0021, 32'h0);
        single("beq",   32'h00208863,  32'h0000_0200, 3'd3, 32'h0000_0010, 3'd3, 64'h0000_0000_0000_0010, 32'h0000_0210);
        single("bne",   32'hFE001FE3,  32'h0000_0010, 3'd3, 32'hFFFF_FFFE, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_000E);
        single("bltu",  32'hFE006FE3,  32'h0000_0010, 3'd3, 32'hFFFF_FFFE, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_000E);
        single("auipc", 32'hFFFFF097,  32'h0000_2000, 3'd4, 32'hFFFF_F000, 3'd4, 64'hFFFF_FFFF_FFFF_F000, 32'h0000_1000);
        single("jalr",  32'hFF008067,  32'h0000_0020, 3'd1, 32'hFFFF_FFF0, 3'd1, 64'hFFFF_FFFF_FFFF_FFF0, 32'h0);
        single("lw",    32'h7FF12083,  32'h0000_0024, 3'd1, 32'h0000_07FF, 3'd1, 64'h0000_0000_0000_07FF, 32'h0);
        single("add",   32'h002081B3,  32'h0000_0028, 3'd0, 32'h0000_0000, 3'd0, 64'h0000_0000_0000_0000, 32'h0);

        // Drain the last result
        @(negedge clk);
        check("idle.valid", 64'(out_valid), 64'd0);

        // Backpressure: four instructions, out_ready low for three cycles
        out_ready = 1'b0;
        drive(1'b1, I_ADDI, 32'h40);
        check("bp.rdy0", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("bp.A.out", 64'(out_instr), 64'(I_ADDI));
        check("bp.rdy1", 64'(in_ready), 64'd1);
        drive(1'b1, I_SW, 32'h44);
        @(negedge clk);
        check("bp.rdy2", 64'(in_ready), 64'd0);
        check("bp.A.hold1", 64'(out_instr), 64'(I_ADDI));
        check("bp.A.imm1", 64'(out_sextimm), 64'hFFFF_FFFF);
        drive(1'b1, I_LUI, 32'h48);
        @(negedge clk);
        check("bp.rdy3", 64'(in_ready), 64'd0);
        check("bp.A.hold2", 64'(out_instr), 64'(I_ADDI));
        check("bp.A.valid", 64'(out_valid), 64'd1);
        check("bp.A.pc", 64'(out_pc), 64'h40);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.B.out", 64'(out_instr), 64'(I_SW));
        check("bp.B.imm", 64'(out_sextimm), 64'hFFFF_FFFC);
        check("bp.rdy4", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("bp.C.out", 64'(out_instr), 64'(I_LUI));
        check("bp.C.pc", 64'(out_pc), 64'h48);
        drive(1'b1, I_JAL, 32'h100);
        @(negedge clk);
        check("bp.D.out", 64'(out_instr), 64'(I_JAL));
        check("bp.D.valid", 64'(out_valid), 64'd1);
        check("bp.D.fmt", 64'(out_fmt), 64'd5);
        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("bp.end.valid", 64'(out_valid), 64'd0);

        // Flush with output and skid full, input presented in the flush cycle
        out_ready = 1'b0;
        drive(1'b1, I_ADDI, 32'h80);
        @(negedge clk);
        drive(1'b1, I_SW, 32'h84);
        @(negedge clk);
        check("fl.full.rdy", 64'(in_ready), 64'd0);
        drive(1'b1, I_LUI, 32'h88);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        out_ready = 1'b1;
        check("fl.valid", 64'(out_valid), 64'd0);
        check("fl.rdy", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fl.quiet", 64'(out_valid), 64'd0);
        end

        // Flush in the same cycle as an accept into a free skid
        out_ready = 1'b0;
        drive(1'b1, I_ADDI, 32'h90);
        @(negedge clk);
        drive(1'b1, I_SW, 32'h94);
        check("fl2.rdy", 64'(in_ready), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        out_ready = 1'b1;
        check("fl2.valid", 64'(out_valid), 64'd0);
        check("fl2.rdy1", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("fl2.quiet", 64'(out_valid), 64'd0);

        single("postfl", I_SW, 32'h98, 3'd2, 32'hFFFF_FFFC, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0);

        // Asynchronous reset while both entries are full
        out_ready = 1'b0;
        drive(1'b1, I_LUI, 32'hA0);
        @(negedge clk);
        drive(1'b1, I_JAL, 32'hA4);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.rdy", 64'(in_ready), 64'd1);
        check("arst.instr", 64'(out_instr), 64'd0);
        check("arst.imm", 64'(out_sextimm), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("arst.after", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, handshaked immediate-generation stage for the simple CPU's decode path.
- Accepts a fetched instruction and PC and classifies the instruction format (I/S/B/U/J/shift).
- Emits the sign-extended immediate one cycle later through a valid/ready interface.
- A two-entry skid buffer sustains full throughput under backpressure and supports pipeline flush.

Parameters:
- DATA_WIDTH, 32, immediate/PC width; legal values 32 or 64 (64 enables RV64 shamt[5] and OP-IMM-32 opcode 0011011).
- FMT_WIDTH, 3, width of the format code output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  discard all buffered entries.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32  instruction word.
- in_pc  input  DATA_WIDTH  instruction PC.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_instr  output  32  instruction passed through.
- out_pc  output  DATA_WIDTH  PC passed through.
- out_sextimm  output  DATA_WIDTH  extended immediate.
- out_fmt  output  FMT_WIDTH  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.

Behaviour:
- Reset: the clock is clk; reset is asynchronous and active-low on rstn.
  - While rstn is low: out_valid=0, in_ready=1, out_sextimm=0, out_fmt=0, out_instr=0, out_pc=0.
  - The skid entry is marked empty.
  - Reset asserted mid-transfer drops everything; no partial state survives.
- Decode rules (standard RV, always sign-extended from the top immediate bit to DATA_WIDTH):
  - I: opcodes 0000011, 1100111, and 0010011 with funct3 not 001/101 → imm[11:0]=instr[31:20].
  - SHAMT: 0010011 (and 0011011 when DATA_WIDTH=64) with funct3 001/101 → zero-extended instr[24:20] (DATA_WIDTH=32) or instr[25:20] (DATA_WIDTH=64); instr[30] does not affect the value.
  - S: 0100011 → {instr[31:25],instr[11:7]}.
  - B: 1100011 → {instr[31],instr[7],instr[30:25],instr[11:8],0}; unsigned branches are also sign-extended.
  - U: 0110111, 0010111 → {instr[31:12],12'b0}, sign-extended when DATA_WIDTH=64.
  - J: 1101111 → {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - Any other opcode → fmt NONE, imm 0; still passed through, never dropped.
- Latency: exactly 1 cycle from accept (in_valid&in_ready) to out_valid with no backpressure.
- Buffering: one output register plus one skid register.
  - in_ready = skid empty (registered).
  - Accept while output full and out_ready=0 → the entry goes to the skid register; in_ready drops next cycle.
  - When output drains, the skid entry moves to the output register in the same cycle; in_ready rises the following cycle.
  - Order is strictly preserved.
- Handshake: out_* hold stable while out_valid=1 and out_ready=0. out_valid never deasserts without a transfer except on flush or reset.
- Flush:
  - Next cycle out_valid=0 and the skid register is empty.
  - An input accepted in the same cycle as flush is discarded; flush wins.
  - in_ready=1 the cycle after flush.
- Simultaneous output drain and input accept with output full and skid empty: the new entry goes to the output register; the skid stays empty.

Optional Feature:
- Macro: IMM_GEN_TARGET_EN.
- With macro: adds output out_target (DATA_WIDTH), registered alongside out_sextimm.
  - For B, J, U-auipc (0010111) it equals out_pc + out_sextimm, modulo 2^DATA_WIDTH (wrap, no overflow flag).
  - For all other formats it is 0.
  - Reset value 0.
- Without macro: port absent, no adder inferred; all other behaviour identical.

Decomposition:
- Package imm_gen_pkg holds:
  - format code localparams (FMT_NONE..FMT_SHAMT);
  - opcode constants (OP_LOAD, OP_IMM, OP_IMM32, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
- One combinational sub-module, imm_decode: takes instr and produces sextimm and fmt.
- imm_gen_stage instantiates imm_decode once on the input side and registers its results with the skid logic.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle out_valid=1, fmt=1, sextimm=0xFFFFFFFF.
- sw x1,-4(x2) (0xFE112E23) → fmt=2, sextimm=0xFFFFFFFC; lui x5,0x12345 (0x123452B7) → fmt=4, sextimm=0x12345000.
- jal x0,-8 (0xFF9FF06F) at pc=0x100 → fmt=5, sextimm=0xFFFFFFF8; with IMM_GEN_TARGET_EN, out_target=0x000000F8.
- srai x1,x1,3 (0x4030D093) → fmt=6, sextimm=0x00000003; DATA_WIDTH=64 with shamt=33 → sextimm=0x21.
- Backpressure: stream of 4 instructions with out_ready held 0 for 3 cycles.
  - in_ready falls after 2 accepts.
  - Outputs stay stable while stalled.
  - All 4 appear in order once out_ready=1.
  - Back-to-back 1/cycle throughput resumes.
- Flush with both entries full plus an input accepted the same cycle → next cycle out_valid=0, in_ready=1; none of the 3 entries ever appears at the output.
